// File: rtl/ws_pkg.sv
// Shared definitions for the water sensing front end.
//   flow_state_e : flow supervision FSM states (OFF, GRACE, MONITOR, FAULT)
//   LEVEL_BANDS  : number of quantised drum level bands
//   BAND_WIDTH   : ADC codes per level band
//   PULSE_SAT    : saturation value of the 8-bit pulse counter
//   band_of()    : maps an 8-bit level code to its raw band index
package ws_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    GRACE   = 2'd1,
    MONITOR = 2'd2,
    FAULT   = 2'd3
  } flow_state_e;

  localparam int         LEVEL_BANDS = 8;
  localparam int         BAND_WIDTH  = 32;
  localparam logic [7:0] PULSE_SAT   = 8'd255;

  function automatic logic [2:0] band_of(input logic [7:0] code);
    int b;
    b = int'(code) / BAND_WIDTH;
    if (b > LEVEL_BANDS - 1) b = LEVEL_BANDS - 1;
    return 3'(b);
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Brings an asynchronous pulse into the clk domain and flags each rising edge.
//   clk      in  system clock
//   reset    in  asynchronous, active-high
//   async_i  in  raw pulse, asynchronous to clk
//   event_o  out one-cycle event per synchronised rising edge
// Two flops form the synchroniser; a third holds the previous synced value.
module pulse_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic event_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // High while the synced level has just risen; consumed at the next edge.
  assign event_o = sync2_q & ~prev_q;

endmodule

// File: rtl/water_sense_conditioner.sv
// Conditions raw water sensing for the washing-machine controller.
//   clk                  in  system clock
//   reset                in  asynchronous, active-high
//   flow_pulse_async     in  raw flow-meter pulse (asynchronous)
//   valve_open           in  inlet valve command
//   level_sample[7:0]    in  level ADC code
//   level_valid          in  qualifies level_sample for one cycle
//   waterflow            out 1 = supply OK / not yet judged, 0 = flow fault
//   water_level_reading  out quantised drum level 0..7
//   flow_count[7:0]      out pulse count of the last completed window
//   flow_state[1:0]      out supervision FSM state
// Handshake: level_valid is a single-cycle qualifier with no back-pressure;
// every cycle it is high, level_sample is consumed.
// Optional feature: define LEVEL_HYST_EN to add HYST codes of hysteresis
// around the level band boundaries.
module water_sense_conditioner
  import ws_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int MIN_PULSES    = 4,
  parameter int GRACE_WINDOWS = 3,
  parameter int AVG_SHIFT     = 2,
  parameter int HYST          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flow_pulse_async,
  input  logic       valve_open,
  input  logic [7:0] level_sample,
  input  logic       level_valid,
  output logic       waterflow,
  output logic [2:0] water_level_reading,
  output logic [7:0] flow_count,
  output logic [1:0] flow_state
);

  localparam int         WCNT_W = $clog2(WINDOW_CYCLES);
  localparam int         GCNT_W = $clog2(GRACE_WINDOWS + 1);
  localparam int         ACC_W  = 8 + AVG_SHIFT;
  localparam logic [7:0] MIN_P  = 8'(MIN_PULSES);

  if (WINDOW_CYCLES < 2 || GRACE_WINDOWS < 1 || AVG_SHIFT < 1 ||
      MIN_PULSES < 0 || MIN_PULSES > 255 || HYST < 0 || HYST >= BAND_WIDTH) begin : g_bad_param
    $error("water_sense_conditioner: parameter out of range");
  end

  // ---------------- pulse path and measurement window ----------------
  logic              pulse_evt;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [7:0]        pcnt_q, pcnt_d;
  logic [7:0]        flow_count_q, flow_count_d;
  logic [7:0]        window_total;
  logic              wrap;
  logic              restart;

  pulse_sync_edge u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (flow_pulse_async),
    .event_o (pulse_evt)
  );

  flow_state_e       state_q, state_d;
  logic [GCNT_W-1:0] grace_cnt_q, grace_cnt_d;
  logic              waterflow_q;

  assign wrap    = (wcnt_q == WCNT_W'(WINDOW_CYCLES - 1));
  assign restart = (state_q == OFF) && valve_open;

  // Running count including this cycle's event, held at saturation.
  assign window_total = (pcnt_q == PULSE_SAT) ? PULSE_SAT : pcnt_q + {7'd0, pulse_evt};

  always_comb begin
    wcnt_d       = wcnt_q + 1'b1;
    pcnt_d       = window_total;
    flow_count_d = flow_count_q;
    if (wrap) flow_count_d = window_total;
    if (wrap || restart) begin
      wcnt_d = '0;
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q       <= '0;
      pcnt_q       <= '0;
      flow_count_q <= '0;
    end else begin
      wcnt_q       <= wcnt_d;
      pcnt_q       <= pcnt_d;
      flow_count_q <= flow_count_d;
    end
  end

  // ---------------- flow supervision FSM ----------------
  always_comb begin
    state_d     = state_q;
    grace_cnt_d = grace_cnt_q;
    // Closing the valve wins over any window decision in the same cycle.
    if (state_q != OFF && !valve_open) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: begin
          if (valve_open) begin
            state_d     = GRACE;
            grace_cnt_d = '0;
          end
        end
        GRACE: begin
          if (wrap) begin
            grace_cnt_d = grace_cnt_q + 1'b1;
            // The window that ends the grace period is not judged.
            if (grace_cnt_q + 1'b1 == GCNT_W'(GRACE_WINDOWS)) state_d = MONITOR;
          end
        end
        MONITOR: if (wrap && window_total < MIN_P)  state_d = FAULT;
        FAULT:   if (wrap && window_total >= MIN_P) state_d = MONITOR;
        default: state_d = OFF;
      endcase
    end
  end

  // waterflow follows the next state so it moves together with flow_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= OFF;
      grace_cnt_q <= '0;
      waterflow_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      grace_cnt_q <= grace_cnt_d;
      waterflow_q <= (state_d != FAULT);
    end
  end

  // ---------------- level averaging and quantisation ----------------
  logic [ACC_W-1:0]     acc_q, acc_d, acc_sum;
  logic [AVG_SHIFT-1:0] scnt_q, scnt_d;
  logic [7:0]           avg;
  logic [2:0]           raw_band;
  logic [2:0]           band_new;
  logic [2:0]           level_q, level_d;

  assign acc_sum  = acc_q + ACC_W'(level_sample);
  assign avg      = 8'(acc_sum >> AVG_SHIFT);
  assign raw_band = band_of(avg);

`ifdef LEVEL_HYST_EN
  // Moving up needs HYST codes past the target band's floor; if the raw band
  // misses that, the band just below it always clears it. Moving down needs
  // HYST codes below the current band's floor.
  always_comb begin
    band_new = level_q;
    if (raw_band > level_q) begin
      if (int'(avg) >= int'(raw_band) * BAND_WIDTH + HYST) band_new = raw_band;
      else if (raw_band - 3'd1 > level_q)                   band_new = raw_band - 3'd1;
    end else if (raw_band < level_q) begin
      if (int'(avg) < int'(level_q) * BAND_WIDTH - HYST) band_new = raw_band;
    end
  end
`else
  assign band_new = raw_band;
`endif

  always_comb begin
    acc_d   = acc_q;
    scnt_d  = scnt_q;
    level_d = level_q;
    if (level_valid) begin
      if (&scnt_q) begin
        acc_d   = '0;
        scnt_d  = '0;
        level_d = band_new;
      end else begin
        acc_d  = acc_sum;
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      scnt_q  <= '0;
      level_q <= '0;
    end else begin
      acc_q   <= acc_d;
      scnt_q  <= scnt_d;
      level_q <= level_d;
    end
  end

  assign waterflow           = waterflow_q;
  assign water_level_reading = level_q;
  assign flow_count          = flow_count_q;
  assign flow_state          = state_q;

endmodule

// File: tb/tb_water_sense_conditioner.sv
module tb_water_sense_conditioner;

  localparam int W     = 100;
  localparam int MINP  = 4;
  localparam int GW    = 2;
  localparam int HYST  = 4;
  localparam int SAT_W = 700;
  localparam int S_OFF = 0, S_GRACE = 1, S_MON = 2, S_FAULT = 3;
  localparam int EW    = 46;  // {cycle[31:0], waterflow, level[2:0], flow_count[7:0], state[1:0]}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flow_pulse_async = 1'b0;
  logic       valve_open = 1'b1;
  logic [7:0] level_sample = 8'd0;
  logic       level_valid = 1'b0;
  logic       waterflow;
  logic [2:0] water_level_reading;
  logic [7:0] flow_count;
  logic [1:0] flow_state;

  logic       sat_reset = 1'b1;
  logic       sat_pulse = 1'b0;
  logic       sat_waterflow;
  logic [2:0] sat_level;
  logic [7:0] sat_flow_count;
  logic [1:0] sat_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  water_sense_conditioner #(
    .WINDOW_CYCLES(W), .MIN_PULSES(MINP), .GRACE_WINDOWS(GW), .AVG_SHIFT(2), .HYST(HYST)
  ) dut (
    .clk(clk), .reset(reset), .flow_pulse_async(flow_pulse_async), .valve_open(valve_open),
    .level_sample(level_sample), .level_valid(level_valid), .waterflow(waterflow),
    .water_level_reading(water_level_reading), .flow_count(flow_count), .flow_state(flow_state)
  );

  water_sense_conditioner #(.WINDOW_CYCLES(SAT_W)) u_sat (
    .clk(clk), .reset(sat_reset), .flow_pulse_async(sat_pulse), .valve_open(1'b0),
    .level_sample(8'd0), .level_valid(1'b0), .waterflow(sat_waterflow),
    .water_level_reading(sat_level), .flow_count(sat_flow_count), .flow_state(sat_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    sat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  function automatic logic [13:0] pack_t(input logic wf, input logic [2:0] lvl,
                                         input logic [7:0] fc, input logic [1:0] st);
    return {wf, lvl, fc, st};
  endfunction

  // ---------------- reference model ----------------
  // Window phase, raw (unsaturated) pulse tally, supervision state and the
  // list of level samples collected toward the next average.
  int   m_phase = 0, m_pcnt = 0, m_fc = 0, m_st = S_OFF, m_gwin = 0, m_lvl = 0;
  logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;   // raw pulse seen at the last three edges
  int   lvl_list[$];
  logic [13:0] m_prev = 14'b1_000_00000000_00;

  function automatic int next_band(input int avg, input int cur);
    int raw, best;
    raw  = avg / 32;
    best = raw;
`ifdef LEVEL_HYST_EN
    best = cur;
    for (int b = cur + 1; b <= raw; b++)
      if (avg >= b * 32 + HYST) best = b;
    if (raw < cur && avg < cur * 32 - HYST) best = raw;
`endif
    return best;
  endfunction

  task automatic expect_now(input int stamp);
    logic [13:0] t;
    t = pack_t(m_st != S_FAULT, 3'(m_lvl), 8'(m_fc), 2'(m_st));
    if (t != m_prev) begin
      exp_q.push_back({32'(stamp), t});
      m_prev = t;
    end
  endtask

  always @(posedge clk or posedge reset) begin : model
    int   done, sum;
    logic ev, wrap, start;
    if (reset) begin
      m_phase = 0; m_pcnt = 0; m_fc = 0; m_st = S_OFF; m_gwin = 0; m_lvl = 0;
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
      lvl_list.delete();
      expect_now(cyc);
    end else begin
      // a rise between the edges three and two back is counted now
      ev    = h1 && !h2;
      wrap  = (m_phase == W - 1);
      start = (m_st == S_OFF) && valve_open;
      done  = m_pcnt + int'(ev);
      if (wrap) m_fc = (done > 255) ? 255 : done;
      if (m_st != S_OFF && !valve_open) m_st = S_OFF;
      else if (m_st == S_OFF) begin
        if (valve_open) begin m_st = S_GRACE; m_gwin = 0; end
      end else if (m_st == S_GRACE) begin
        if (wrap) begin m_gwin++; if (m_gwin == GW) m_st = S_MON; end
      end else if (m_st == S_MON) begin
        if (wrap && done < MINP) m_st = S_FAULT;
      end else begin
        if (wrap && done >= MINP) m_st = S_MON;
      end
      m_pcnt  = (wrap || start) ? 0 : done;
      m_phase = (wrap || start) ? 0 : m_phase + 1;
      h2 = h1; h1 = h0; h0 = flow_pulse_async;
      if (level_valid) begin
        lvl_list.push_back(int'(level_sample));
        if (lvl_list.size() == 4) begin
          sum = 0;
          foreach (lvl_list[i]) sum += lvl_list[i];
          m_lvl = next_band(sum / 4, m_lvl);
          lvl_list.delete();
        end
      end
      expect_now(cyc + 1);
    end
  end

  // ---------------- monitors ----------------
  logic [13:0] mon_prev = 14'b1_000_00000000_00;
  logic [7:0]  sat_prev = 8'd0;

  always @(negedge clk) begin
    logic [13:0]   cur;
    logic [EW-1:0] e;
    cur = pack_t(waterflow, water_level_reading, flow_count, flow_state);
    if (cur !== mon_prev) begin
      if (exp_q.size() == 0) check("unexpected_output_change", 32'(cur), 32'(mon_prev));
      else begin
        e = exp_q.pop_front();
        check("output_change_cycle", 32'(cyc), e[45:14]);
        check("output_change_value", 32'(cur), 32'(e[13:0]));
      end
      mon_prev = cur;
    end
    if (sat_flow_count !== sat_prev) begin
      if (sat_q.size() == 0) check("sat_unexpected_change", 32'(sat_flow_count), 32'(sat_prev));
      else check("sat_flow_count", 32'(sat_flow_count), 32'(sat_q.pop_front()));
      sat_prev = sat_flow_count;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p, input int budget);
    int k = 0;
    while (m_phase != p && k < budget) begin wait_cycles(1); k++; end
    if (m_phase != p) check("wait_phase_timeout", 32'(m_phase), 32'(p));
  endtask

  task automatic pulse_burst(input int n, input int hi, input int lo, input bit to_sat);
    for (int i = 0; i < n; i++) begin
      if (to_sat) sat_pulse = 1'b1; else flow_pulse_async = 1'b1;
      wait_cycles(hi);
      if (to_sat) sat_pulse = 1'b0; else flow_pulse_async = 1'b0;
      wait_cycles(lo);
    end
  endtask

  task automatic level_push(input int v, input int gap);
    level_valid  = 1'b1;
    level_sample = 8'(v);
    wait_cycles(1);
    level_valid  = 1'b0;
    level_sample = 8'($urandom_range(0, 255));
    wait_cycles(gap);
  endtask

  task automatic feed4(input int v, input int exp_lvl);
    for (int i = 0; i < 4; i++) level_push(v, (i < 3) ? $urandom_range(0, 3) : 0);
    check("level_after_4th_valid", 32'(water_level_reading), 32'(exp_lvl));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int npulse;
    wait_cycles(3);
    check("reset_waterflow", 32'(waterflow), 32'd1);
    check("reset_level", 32'(water_level_reading), 32'd0);
    check("reset_flow_count", 32'(flow_count), 32'd0);
    check("reset_state", 32'(flow_state), 32'd0);

    // valve held open through reset; GRACE one edge after release
    reset = 1'b0;
    wait_cycles(1);
    check("grace_after_release", 32'(flow_state), 32'd1);
    wait_cycles(199);
    check("still_grace_at_199", 32'(flow_state), 32'd1);
    wait_cycles(1);
    check("monitor_at_200", 32'(flow_state), 32'd2);
    check("waterflow_at_200", 32'(waterflow), 32'd1);
    wait_cycles(100);
    check("fault_at_300", 32'(flow_state), 32'd3);
    check("waterflow_low_at_300", 32'(waterflow), 32'd0);

    // level averaging
    feed4(100, 3);
`ifdef LEVEL_HYST_EN
    feed4(130, 3);
    feed4(136, 4);
`else
    feed4(130, 4);
    feed4(136, 4);
`endif

    // six pulses in one window while in FAULT
    pulse_burst(6, 2, 2, 1'b0);
    wait_phase(0, 200);
    check("flow_count_six", 32'(flow_count), 32'd6);
    check("recover_state", 32'(flow_state), 32'd2);
    check("recover_waterflow", 32'(waterflow), 32'd1);

    // valve drop coincident with a zero-pulse wrap
    wait_phase(W - 1, 200);
    valve_open = 1'b0;
    wait_cycles(1);
    check("valve_drop_state", 32'(flow_state), 32'd0);
    check("valve_drop_waterflow", 32'(waterflow), 32'd1);
    check("valve_drop_flow_count", 32'(flow_count), 32'd0);

    // randomized operation
    for (int it = 0; it < 8; it++) begin
      valve_open = 1'b1;
      repeat ($urandom_range(2, 5)) begin
        pulse_burst($urandom_range(0, 8), $urandom_range(1, 3), $urandom_range(1, 4), 1'b0);
        repeat ($urandom_range(1, 4)) level_push($urandom_range(0, 255), $urandom_range(0, 3));
        wait_cycles($urandom_range(5, 60));
      end
      if ($urandom_range(0, 2) == 0) begin
        valve_open = 1'b0;
        wait_cycles($urandom_range(1, 5));
      end
    end

    // heavy pulse train, then reset in the middle of a window
    valve_open = 1'b1;
    for (int i = 0; i < 4; i++) level_push(200, $urandom_range(0, 2));
    pulse_burst(300, 1, 1, 1'b0);
    wait_phase(50, 200);
    reset = 1'b1;
    #1;
    check("midreset_waterflow", 32'(waterflow), 32'd1);
    check("midreset_level", 32'(water_level_reading), 32'd0);
    check("midreset_flow_count", 32'(flow_count), 32'd0);
    check("midreset_state", 32'(flow_state), 32'd0);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(20);

    // saturation: 300 pulses inside one long window
    sat_reset = 1'b0;
    npulse = 300;
    sat_q.push_back(8'((npulse > 255) ? 255 : npulse));
    pulse_burst(npulse, 1, 1, 1'b1);
    wait_cycles(SAT_W - 2 * npulse + 20);
    check("sat_flow_count_final", 32'(sat_flow_count), 32'd255);

    wait_cycles(5);
    check("expected_queue_drained", 32'(exp_q.size()), 32'd0);
    check("sat_queue_drained", 32'(sat_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
